dmem_arbiter: RTL and testbench

Arbiter for the single-port data memory, shared between the pipeline memory stage (CPU) and the matrix-MAC load/store engine (MAC). It sits between both requesters and the data memory: it muxes address, write data and write enable, returns read data, and stalls the pipeline when the MAC is granted. The CPU has priority by default. A starvation counter forces a MAC grant after a bounded number of lost cycles.

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the pipeline memory stage (CPU)
// and the matrix-MAC load/store engine (MAC). By default the CPU has priority.
// A starvation counter forces one MAC grant after STARVE_MAX consecutive
// cycles in which the MAC lost to the CPU. While the MAC holds memory against
// a pending CPU access, the pipeline is stalled.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata  CPU access request and payload
//   cpu_rdata           CPU load data (combinational from memory)
//   cpu_stall           freeze the pipeline this cycle
//   mac_req/we/addr/wdata  MAC request and payload (held until mac_gnt)
//   mac_gnt             MAC request accepted this cycle
//   mac_rvalid/rdata    registered MAC load result, one cycle after grant
//   mem_we/addr/wdata   to the data memory (synchronous write)
//   mem_rdata           from the data memory (combinational read)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          mac_req,
    input  logic          mac_we,
    input  logic [AW-1:0] mac_addr,
    input  logic [DW-1:0] mac_wdata,
    output logic          mac_gnt,
    output logic          mac_rvalid,
    output logic [DW-1:0] mac_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Counter holds 0..STARVE_MAX.
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    typedef enum logic {
        CPU_PRI = 1'b0,
        MAC_PRI = 1'b1
    } mode_t;

    mode_t         mode_r;
    mode_t         mode_next_s;
    logic [SW-1:0] starve_r;
    logic [SW-1:0] starve_next_s;
    logic          mac_owns_s;
    logic          cpu_owns_s;
    logic          mac_rvalid_r;
    logic [DW-1:0] mac_rdata_r;

    // Ownership decision for the current cycle.
    always_comb begin
        mac_owns_s = 1'b0;
        case (mode_r)
            CPU_PRI: mac_owns_s = mac_req & ~cpu_req;
            // An idle MAC in MAC_PRI is a protocol violation; the CPU then
            // falls through exactly as in CPU_PRI.
            MAC_PRI: mac_owns_s = mac_req;
            default: mac_owns_s = 1'b0;
        endcase
        cpu_owns_s = cpu_req & ~mac_owns_s;
    end

    // Memory-side mux and requester-side handshakes.
    always_comb begin
        mac_gnt   = mac_owns_s;
        cpu_stall = mac_owns_s & cpu_req;
        cpu_rdata = mem_rdata;
        if (mac_owns_s) begin
            mem_we    = mac_we;
            mem_addr  = mac_addr;
            mem_wdata = mac_wdata;
        end else if (cpu_owns_s) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Next mode and starvation count.
    always_comb begin
        mode_next_s   = CPU_PRI;
        starve_next_s = {SW{1'b0}};
        case (mode_r)
            CPU_PRI: begin
                if (mac_req && cpu_req) begin
                    starve_next_s = starve_r + SW'(1);
                    if (starve_r >= STARVE_LAST) begin
                        mode_next_s = MAC_PRI;
                    end else begin
                        mode_next_s = CPU_PRI;
                    end
                end else begin
                    // MAC either granted or not asking: nothing owed.
                    starve_next_s = {SW{1'b0}};
                    mode_next_s   = CPU_PRI;
                end
            end
            // The forced grant lasts exactly one cycle.
            MAC_PRI: begin
                mode_next_s   = CPU_PRI;
                starve_next_s = {SW{1'b0}};
            end
            default: begin
                mode_next_s   = CPU_PRI;
                starve_next_s = {SW{1'b0}};
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r   <= CPU_PRI;
            starve_r <= {SW{1'b0}};
        end else begin
            mode_r   <= mode_next_s;
            starve_r <= starve_next_s;
        end
    end

    // MAC load return path: capture memory data after a granted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_rvalid_r <= 1'b0;
            mac_rdata_r  <= {DW{1'b0}};
        end else begin
            mac_rvalid_r <= mac_owns_s & ~mac_we;
            if (mac_owns_s && !mac_we) begin
                mac_rdata_r <= mem_rdata;
            end else begin
                mac_rdata_r <= mac_rdata_r;
            end
        end
    end

    assign mac_rvalid = mac_rvalid_r;
    assign mac_rdata  = mac_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Table-driven bench for dmem_arbiter with a behavioural data memory
// (synchronous write, combinational read). Each vector drives both requesters
// for one cycle and states the expected grant, stall, memory write enable,
// memory address and (optionally) CPU load data. Expected MAC load data is
// pushed to a scoreboard queue at grant time and popped when mac_rvalid is
// checked the following cycle. Hand-written sequences cover asynchronous
// reset in the middle of traffic.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req, cpu_we, mac_req, mac_we;
    logic [AW-1:0] cpu_addr, mac_addr;
    logic [DW-1:0] cpu_wdata, mac_wdata;
    logic [DW-1:0] cpu_rdata, mac_rdata, mem_wdata, mem_rdata;
    logic          cpu_stall, mac_gnt, mac_rvalid, mem_we;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem [0:255];

    int n_total = 0;
    int n_pass  = 0;

    logic [DW-1:0] sb_q [$];
    bit            pending_rv = 1'b0;

    typedef struct {
        string         name;
        logic          cpu_req;
        logic          cpu_we;
        logic [AW-1:0] cpu_addr;
        logic [DW-1:0] cpu_wdata;
        logic          mac_req;
        logic          mac_we;
        logic [AW-1:0] mac_addr;
        logic [DW-1:0] mac_wdata;
        logic          exp_gnt;
        logic          exp_stall;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic          chk_rd;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] exp_mrd;
    } vec_t;

    vec_t tbl [$];

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mac_req    (mac_req),
        .mac_we     (mac_we),
        .mac_addr   (mac_addr),
        .mac_wdata  (mac_wdata),
        .mac_gnt    (mac_gnt),
        .mac_rvalid (mac_rvalid),
        .mac_rdata  (mac_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural data memory, word addressed.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    endtask

    function automatic vec_t mk(input string nm,
                                input logic creq, input logic cwe,
                                input logic [31:0] caddr, input logic [31:0] cwd,
                                input logic mreq, input logic mwe,
                                input logic [31:0] maddr, input logic [31:0] mwd,
                                input logic egnt, input logic estall, input logic ewe,
                                input logic [31:0] eaddr, input logic chkrd,
                                input logic [31:0] erd, input logic [31:0] emrd);
        vec_t v;
        v.name = nm;       v.cpu_req = creq;  v.cpu_we = cwe;
        v.cpu_addr = caddr; v.cpu_wdata = cwd;
        v.mac_req = mreq;  v.mac_we = mwe;   v.mac_addr = maddr; v.mac_wdata = mwd;
        v.exp_gnt = egnt;  v.exp_stall = estall; v.exp_we = ewe;
        v.exp_addr = eaddr; v.chk_rd = chkrd; v.exp_rd = erd; v.exp_mrd = emrd;
        return v;
    endfunction

    task automatic drive_idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        mac_req = 1'b0; mac_we = 1'b0; mac_addr = 32'h0; mac_wdata = 32'h0;
    endtask

    // Entered just after a posedge; leaves just after the next posedge.
    task automatic apply_vec(input vec_t v);
        cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
        mac_req = v.mac_req; mac_we = v.mac_we; mac_addr = v.mac_addr; mac_wdata = v.mac_wdata;
        @(negedge clk);
        chk({v.name, "/mac_gnt"},   {31'd0, mac_gnt},   {31'd0, v.exp_gnt});
        chk({v.name, "/cpu_stall"}, {31'd0, cpu_stall}, {31'd0, v.exp_stall});
        chk({v.name, "/mem_we"},    {31'd0, mem_we},    {31'd0, v.exp_we});
        chk({v.name, "/mem_addr"},  mem_addr,           v.exp_addr);
        if (v.chk_rd) chk({v.name, "/cpu_rdata"}, cpu_rdata, v.exp_rd);
        chk({v.name, "/mac_rvalid"}, {31'd0, mac_rvalid}, {31'd0, pending_rv});
        if (pending_rv) begin
            if (sb_q.size() == 0) chk({v.name, "/sb_empty"}, 32'd0, 32'd1);
            else chk({v.name, "/mac_rdata"}, mac_rdata, sb_q.pop_front());
        end
        pending_rv = v.exp_gnt && !v.mac_we;
        if (pending_rv) sb_q.push_back(v.exp_mrd);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic pulse_reset(input string nm);
        drive_idle();
        rst = 1'b1;
        #2;
        chk({nm, "/rvalid_in_rst"}, {31'd0, mac_rvalid}, 32'd0);
        chk({nm, "/rdata_in_rst"},  mac_rdata, 32'd0);
        chk({nm, "/gnt_in_rst"},    {31'd0, mac_gnt}, 32'd0);
        sb_q.delete();
        pending_rv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive_idle();
        // Reset state with no requests.
        #12;
        chk("rst/mac_gnt",    {31'd0, mac_gnt},    32'd0);
        chk("rst/cpu_stall",  {31'd0, cpu_stall},  32'd0);
        chk("rst/mem_we",     {31'd0, mem_we},     32'd0);
        chk("rst/mac_rvalid", {31'd0, mac_rvalid}, 32'd0);
        chk("rst/mac_rdata",  mac_rdata,           32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //           name        creq cwe  caddr     cwdata        mreq mwe  maddr     mwdata        gnt  stl  we   eaddr     chk  cpu_rdata     mac_rdata
        tbl.push_back(mk("cpu_st", 1'b1,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,1'b1,32'h10,1'b0,32'h0,        32'h0));
        tbl.push_back(mk("cpu_ld", 1'b1,1'b0,32'h10,32'h0,        1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,1'b0,32'h10,1'b1,32'hDEADBEEF,32'h0));
        tbl.push_back(mk("mac_ld", 1'b0,1'b0,32'h0, 32'h0,        1'b1,1'b0,32'h10,32'h0,        1'b1,1'b0,1'b0,32'h10,1'b0,32'h0,        32'hDEADBEEF));
        tbl.push_back(mk("idle1",  1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,        32'h0));
        tbl.push_back(mk("idle2",  1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,        32'h0));
        tbl.push_back(mk("mac_st", 1'b0,1'b0,32'h0, 32'h0,        1'b1,1'b1,32'h20,32'h12345678, 1'b1,1'b0,1'b1,32'h20,1'b0,32'h0,        32'h0));
        tbl.push_back(mk("cpu_ld2",1'b1,1'b0,32'h20,32'h0,        1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,1'b0,32'h20,1'b1,32'h12345678,32'h0));
        tbl.push_back(mk("b2b_a",  1'b0,1'b0,32'h0, 32'h0,        1'b1,1'b0,32'h10,32'h0,        1'b1,1'b0,1'b0,32'h10,1'b0,32'h0,        32'hDEADBEEF));
        tbl.push_back(mk("b2b_b",  1'b0,1'b0,32'h0, 32'h0,        1'b1,1'b0,32'h20,32'h0,        1'b1,1'b0,1'b0,32'h20,1'b0,32'h0,        32'h12345678));
        tbl.push_back(mk("idle3",  1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,        32'h0));
        // Continuous contention: CPU four cycles, then one forced MAC cycle.
        for (int c = 0; c < 2 * (SM + 1); c++) begin
            logic forced;
            forced = ((c % (SM + 1)) == SM);
            tbl.push_back(mk($sformatf("starve%0d", c),
                             1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
                             forced, forced, 1'b0, forced ? 32'h20 : 32'h10,
                             !forced, 32'hDEADBEEF, 32'h12345678));
        end
        tbl.push_back(mk("idle4",  1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,1'b0,32'h0, 1'b0,32'h0,        32'h0));

        for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i]);

        // Reset one cycle after a MAC read grant: in-flight result is dropped.
        apply_vec(mk("rstA_gnt", 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h10,32'h0,
                     1'b1,1'b0,1'b0,32'h10,1'b0,32'h0,32'hDEADBEEF));
        chk("rstA/rvalid_before", {31'd0, mac_rvalid}, 32'd1);
        pulse_reset("rstA");
        apply_vec(mk("rstA_after", 1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,
                     1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,32'h0));

        // Reach MAC_PRI, reset, then contention must start from CPU again.
        for (int c = 0; c < SM; c++)
            apply_vec(mk($sformatf("rstB_pre%0d", c), 1'b1,1'b0,32'h10,32'h0, 1'b1,1'b0,32'h20,32'h0,
                         1'b0,1'b0,1'b0,32'h10,1'b1,32'hDEADBEEF,32'h0));
        pulse_reset("rstB");
        for (int c = 0; c <= SM; c++) begin
            logic forced;
            forced = (c == SM);
            apply_vec(mk($sformatf("rstB_post%0d", c), 1'b1,1'b0,32'h10,32'h0, 1'b1,1'b0,32'h20,32'h0,
                         forced, forced, 1'b0, forced ? 32'h20 : 32'h10,
                         !forced, 32'hDEADBEEF, 32'h12345678));
        end
        apply_vec(mk("rstB_drain", 1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,
                     1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,32'h0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
